// File: rtl/simon_frame_ctrl_pkg.sv
// Shared types and constants for the Simon frame controller.
//   state_e      : controller FSM states
//   ST_*         : reply status bytes
//   MODE_*       : bit positions inside the mode byte
//   mode_legal() : mode byte has its reserved upper bits clear
package simon_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_KEY,
    S_RX_BLK,
    S_DRAIN,
    S_LOAD,
    S_WAIT_CORE,
    S_TX_DATA,
    S_TX_ERR
  } state_e;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADMODE = 8'hE1;
  localparam logic [7:0] ST_NOKEY   = 8'hE2;
  localparam logic [7:0] ST_TIMEOUT = 8'hE3;

  localparam int MODE_DEC   = 0;
  localparam int MODE_REUSE = 1;

  function automatic logic mode_legal(input logic [7:0] mode);
    return mode[7:2] == 6'd0;
  endfunction

endpackage

// File: rtl/simon_frame_ctrl_tx_ser.sv
// Reply serializer: parallel-loads {status, payload} plus a byte count and
// shifts it out MSB-first on a valid/ready byte stream.
//   clk, rst      : clock, async active-low reset
//   load_i        : capture load_data_i / load_cnt_i (only issued while idle)
//   load_data_i   : NBYTES bytes, first byte to send in the top bits
//   load_cnt_i    : number of bytes to send (1 for a status-only reply)
//   ready_i       : downstream accepts data_o
//   valid_o       : a byte is pending
//   data_o        : current byte, stable until accepted
//   last_o        : the pending byte is the final one
module simon_frame_tx_ser #(
  parameter int NBYTES = 5,
  parameter int CW     = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [NBYTES*8-1:0]   load_data_i,
  input  logic [CW-1:0]         load_cnt_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [7:0]            data_o,
  output logic                  last_o
);

  logic [NBYTES*8-1:0] sh_q;
  logic [CW-1:0]       cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= load_data_i;
      cnt_q <= load_cnt_i;
    end else if (valid_o && ready_i) begin
      // zero fill keeps data_o at 0 once the reply has drained
      sh_q  <= {sh_q[NBYTES*8-9:0], 8'h00};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign last_o  = (cnt_q == CW'(1));
  assign data_o  = sh_q[NBYTES*8-1 -: 8];

endmodule

// File: rtl/simon_frame_ctrl.sv
// Byte-framed request controller between a UART byte link and a Simon core.
// Frame: mode, [key bytes], block bytes (MSB first). Reply: 0x00 + result
// bytes, or a single error status byte.
//   clk, rst                : clock, async active-low reset
//   rx_valid/rx_data/rx_ready : inbound byte stream
//   tx_valid/tx_data/tx_ready : outbound reply stream
//   core_load/core_decrypt/core_key/core_blk : request to the core
//   core_done/core_result   : response from the core
//   busy, done_pulse, err_flag : status
//
// state       | meaning
// ------------+-----------------------------------------------
// S_IDLE      | waiting for a mode byte
// S_RX_KEY    | shifting key bytes into the shadow key
// S_RX_BLK    | shifting block bytes
// S_DRAIN     | discarding bytes after a bad request until idle gap
// S_LOAD      | one-cycle start pulse to the core, commit new key
// S_WAIT_CORE | waiting for core_done
// S_TX_DATA   | sending 0x00 + result bytes
// S_TX_ERR    | sending a single error status byte
module simon_frame_ctrl
  import simon_frame_pkg::*;
#(
  parameter int BLK_W       = 32,
  parameter int KEY_W       = 64,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             core_load,
  output logic             core_decrypt,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_blk,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_result,
  output logic             busy,
  output logic             done_pulse,
  output logic             err_flag
);

  localparam int KEY_BYTES = KEY_W / 8;
  localparam int BLK_BYTES = BLK_W / 8;
  localparam int RPL_BYTES = BLK_BYTES + 1;
  localparam int CNT_W     = $clog2(KEY_BYTES + 1);
  localparam int GAP_W     = $clog2(GAP_TIMEOUT + 1);
  localparam int SER_CW    = $clog2(RPL_BYTES + 1);

  // Byte counters are loaded with (bytes-1) and end at zero.
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q;
  logic [7:0]        err_code_q, err_code_d;
  logic              err_flag_q, err_flag_d;
  logic [KEY_W-1:0]  key_sh_q, key_q;
  logic              key_valid_q;
  logic [BLK_W-1:0]  blk_q;
  logic              dec_q, reuse_q, done_q;
  logic              rx_open, rx_fire, gap_run, gap_hit;
  logic              ser_load, tx_last;
  logic [7:0]        ser_status;
  logic [BLK_W-1:0]  ser_payload;
  logic [SER_CW-1:0] ser_cnt;

  assign rx_open = (state_q inside {S_IDLE, S_RX_KEY, S_RX_BLK, S_DRAIN});
  // Gated by rst so rx_ready is low for the whole reset, not just after an edge.
  assign rx_ready = rst & rx_open;
  assign rx_fire  = rx_valid & rx_ready;
  assign gap_run  = (state_q inside {S_RX_KEY, S_RX_BLK, S_DRAIN});
  // A byte arriving on the terminal count cancels the timeout.
  assign gap_hit  = (gap_q == '0) && !rx_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_code_q <= ST_OK;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= GAP_LOAD;
    end else if (rx_fire || !gap_run) begin
      gap_q <= GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_q <= gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sh_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      blk_q       <= '0;
      dec_q       <= 1'b0;
      reuse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_WAIT_CORE) && core_done;
      if (state_q == S_IDLE && rx_fire && mode_legal(rx_data)) begin
        dec_q   <= rx_data[MODE_DEC];
        reuse_q <= rx_data[MODE_REUSE];
      end
      if (state_q == S_RX_KEY && rx_fire) key_sh_q <= {key_sh_q[KEY_W-9:0], rx_data};
      if (state_q == S_RX_BLK && rx_fire) blk_q <= {blk_q[BLK_W-9:0], rx_data};
      // Stored key only changes once a full non-reuse frame has arrived.
      if (state_q == S_LOAD && !reuse_q) begin
        key_q       <= key_sh_q;
        key_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_code_d  = err_code_q;
    err_flag_d  = err_flag_q;
    ser_load    = 1'b0;
    ser_status  = ST_OK;
    ser_payload = '0;
    ser_cnt     = SER_CW'(1);
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (!mode_legal(rx_data)) begin
            err_code_d = ST_BADMODE;
            state_d    = S_DRAIN;
          end else begin
            err_flag_d = 1'b0;
            if (rx_data[MODE_REUSE] && !key_valid_q) begin
              err_code_d = ST_NOKEY;
              state_d    = S_DRAIN;
            end else if (rx_data[MODE_REUSE]) begin
              cnt_d   = BLK_LAST;
              state_d = S_RX_BLK;
            end else begin
              cnt_d   = KEY_LAST;
              state_d = S_RX_KEY;
            end
          end
        end
      end
      S_RX_KEY, S_RX_BLK: begin
        if (rx_fire) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (state_q == S_RX_KEY) begin
            cnt_d   = BLK_LAST;
            state_d = S_RX_BLK;
          end else begin
            state_d = S_LOAD;
          end
        end else if (gap_hit) begin
          ser_load   = 1'b1;
          ser_status = ST_TIMEOUT;
          err_flag_d = 1'b1;
          state_d    = S_TX_ERR;
        end
      end
      S_DRAIN: begin
        if (gap_hit) begin
          ser_load   = 1'b1;
          ser_status = err_code_q;
          err_flag_d = 1'b1;
          state_d    = S_TX_ERR;
        end
      end
      S_LOAD: state_d = S_WAIT_CORE;
      S_WAIT_CORE: begin
        if (core_done) begin
          ser_load    = 1'b1;
          ser_payload = core_result;
          ser_cnt     = SER_CW'(RPL_BYTES);
          state_d     = S_TX_DATA;
        end
      end
      S_TX_DATA, S_TX_ERR: begin
        if (tx_valid && tx_ready && tx_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  simon_frame_tx_ser #(
    .NBYTES (RPL_BYTES),
    .CW     (SER_CW)
  ) u_tx_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .load_data_i ({ser_status, ser_payload}),
    .load_cnt_i  (ser_cnt),
    .ready_i     (tx_ready),
    .valid_o     (tx_valid),
    .data_o      (tx_data),
    .last_o      (tx_last)
  );

  // During LOAD of a fresh-key frame the new key is not yet in key_q.
  assign core_key     = (state_q == S_LOAD && !reuse_q) ? key_sh_q : key_q;
  assign core_load    = (state_q == S_LOAD);
  assign core_decrypt = dec_q;
  assign core_blk     = blk_q;
  assign busy         = (state_q != S_IDLE);
  assign done_pulse   = done_q;
  assign err_flag     = err_flag_q;

endmodule

// File: tb/tb_simon_frame_ctrl.sv
module tb_simon_frame_ctrl;

  localparam int BLK_W = 32;
  localparam int KEY_W = 64;
  localparam int GAP   = 16;
  localparam logic [63:0] K0 = 64'h1918111009080100;
  localparam logic [63:0] K1 = 64'h0123456789abcdef;
  localparam logic [63:0] K2 = 64'hfedcba9876543210;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]       rx_data, tx_data;
  logic             core_load, core_decrypt, core_done, busy, done_pulse, err_flag;
  logic [KEY_W-1:0] core_key;
  logic [BLK_W-1:0] core_blk, core_result;

  simon_frame_ctrl #(.BLK_W(BLK_W), .KEY_W(KEY_W), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .core_load(core_load), .core_decrypt(core_decrypt), .core_key(core_key),
    .core_blk(core_blk), .core_done(core_done), .core_result(core_result),
    .busy(busy), .done_pulse(done_pulse), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] key;
    logic [31:0] blk;
    logic        dec;
  } core_exp_t;

  core_exp_t  core_q[$];
  logic [7:0] reply_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int load_cnt = 0;
  int core_lat = 3;
  bit core_chk = 0;

  // External core stand-in: known Simon32/64 vectors, otherwise a simple mix.
  function automatic logic [31:0] core_fn(input logic [63:0] k, input logic [31:0] b, input logic d);
    if (!d && k == K0 && b == 32'h65656877) return 32'hc69be9bb;
    if (d && k == K0 && b == 32'hc69be9bb) return 32'h65656877;
    return b ^ k[31:0] ^ k[63:32] ^ {32{d}};
  endfunction

  // TX monitor: scoreboard pop, stability under backpressure, done pulses.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  initial forever begin
    @(negedge clk);
    if (rst && hold_v && tx_valid) begin
      vectors++;
      if (tx_data !== hold_d) begin
        miscompares++;
        $display("FAIL tx_stable: tx_data=%h, required %h", tx_data, hold_d);
      end
    end
    hold_v = rst && tx_valid && !tx_ready;
    hold_d = tx_data;
    if (rst && tx_valid && tx_ready) begin
      if (reply_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected: byte %h, required none", tx_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = reply_q.pop_front();
        vectors++;
        if (tx_data !== exp_b) begin
          miscompares++;
          $display("FAIL tx_byte: got %h, required %h", tx_data, exp_b);
        end
      end
    end
    if (rst && done_pulse) done_cnt++;
  end

  // Core model.
  initial forever begin
    @(negedge clk);
    if (rst && core_load) begin
      logic [63:0] ck;
      logic [31:0] cb;
      logic        cd;
      core_exp_t   e;
      ck = core_key; cb = core_blk; cd = core_decrypt;
      load_cnt++;
      core_chk = 1;
      if (core_q.size() == 0) begin
        miscompares++;
        $display("FAIL core_unexpected: load key=%h blk=%h dec=%b, required none", ck, cb, cd);
      end else begin
        e = core_q.pop_front();
        vectors++;
        if ({ck, cb, cd} !== {e.key, e.blk, e.dec}) begin
          miscompares++;
          $display("FAIL core_args: key=%h blk=%h dec=%b, required key=%h blk=%h dec=%b",
                   ck, cb, cd, e.key, e.blk, e.dec);
        end
      end
      repeat (core_lat) @(negedge clk);
      if (core_chk) begin
        vectors++;
        if (core_key !== ck || core_blk !== cb || core_decrypt !== cd) begin
          miscompares++;
          $display("FAIL core_hold: key=%h blk=%h dec=%b, required key=%h blk=%h dec=%b",
                   core_key, core_blk, core_decrypt, ck, cb, cd);
        end
      end
      core_result = core_fn(ck, cb, cd);
      core_done = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (core_chk) begin
        if (!(tx_valid === 1'b1 && tx_data === 8'h00 && done_pulse === 1'b1)) begin
          miscompares++;
          $display("FAIL done_latency: tx_valid=%b tx_data=%h done_pulse=%b, required 1/00/1",
                   tx_valid, tx_data, done_pulse);
        end
      end else begin
        if (busy !== 1'b0 || tx_valid !== 1'b0 || done_pulse !== 1'b0) begin
          miscompares++;
          $display("FAIL done_ignored: busy=%b tx_valid=%b done_pulse=%b, required 0/0/0",
                   busy, tx_valid, done_pulse);
        end
      end
      @(negedge clk);
      core_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      miscompares++;
      $display("FAIL rx_accept: rx_ready=%b, required 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_body(input logic reuse, input logic [63:0] key, input logic [31:0] blk);
    if (!reuse) for (int i = 7; i >= 0; i--) send_byte(key[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(blk[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [7:0] mode, input logic [63:0] key, input logic [31:0] blk);
    send_byte(mode);
    send_body(mode[1], key, blk);
  endtask

  task automatic expect_ok(input logic [63:0] key, input logic [31:0] blk, input logic dec);
    logic [31:0] r;
    core_q.push_back('{key: key, blk: blk, dec: dec});
    r = core_fn(key, blk, dec);
    reply_q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) reply_q.push_back(r[i*8 +: 8]);
  endtask

  task automatic wait_reply_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((reply_q.size() != 0 || busy) && n < 3000);
    vectors++;
    if (reply_q.size() != 0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_reply_end: pending=%0d busy=%b tx_valid=%b, required 0/0/0",
               name, reply_q.size(), busy, tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rx_ready: got %b, required 0", rx_ready);
    end
    vectors++;
    if ({tx_valid, core_load, core_decrypt, busy, done_pulse, err_flag} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b, required 000000",
               {tx_valid, core_load, core_decrypt, busy, done_pulse, err_flag});
    end
    vectors++;
    if (tx_data !== 8'h00 || core_key !== '0 || core_blk !== '0) begin
      miscompares++;
      $display("FAIL reset_data: tx_data=%h key=%h blk=%h, required zeros", tx_data, core_key, core_blk);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_rx_ready: got %b, required 1", rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt();
    int d0;
    d0 = done_cnt;
    expect_ok(K0, 32'h65656877, 1'b0);
    send_frame(8'h00, K0, 32'h65656877);
    vectors++;
    if (core_load !== 1'b1) begin
      miscompares++;
      $display("FAIL load_latency: core_load=%b, required 1", core_load);
    end
    @(posedge clk); #1;
    vectors++;
    if (core_load !== 1'b0) begin
      miscompares++;
      $display("FAIL load_pulse: core_load=%b, required 0", core_load);
    end
    wait_reply_done("encrypt");
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_decrypt_reuse();
    expect_ok(K0, 32'hc69be9bb, 1'b1);
    send_frame(8'h03, 64'h0, 32'hc69be9bb);
    wait_reply_done("decrypt_reuse");
    vectors++;
    if (err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL decrypt_err_flag: got %b, required 0", err_flag);
    end
  endtask

  task automatic test_nokey();
    int l0;
    test_reset();
    l0 = load_cnt;
    reply_q.push_back(8'hE2);
    send_frame(8'h02, 64'h0, 32'h65656877);
    wait_reply_done("nokey");
    vectors++;
    if (err_flag !== 1'b1 || load_cnt != l0) begin
      miscompares++;
      $display("FAIL nokey_status: err_flag=%b loads=%0d, required 1/0", err_flag, load_cnt - l0);
    end
  endtask

  task automatic test_badmode();
    reply_q.push_back(8'hE1);
    send_byte(8'h80);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    wait_reply_done("badmode");
    vectors++;
    if (err_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL badmode_err_flag: got %b, required 1", err_flag);
    end
    expect_ok(K1, 32'hdeadbeef, 1'b0);
    send_byte(8'h00);
    vectors++;
    if (err_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err_flag=%b, required 0", err_flag);
    end
    send_body(1'b0, K1, 32'hdeadbeef);
    wait_reply_done("after_badmode");
  endtask

  task automatic test_timeout();
    reply_q.push_back(8'hE3);
    send_byte(8'h00);
    send_byte(8'haa);
    send_byte(8'hbb);
    send_byte(8'hcc);
    wait_reply_done("timeout");
    vectors++;
    if (err_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err_flag: got %b, required 1", err_flag);
    end
    expect_ok(K1, 32'h13579bdf, 1'b0);
    send_frame(8'h02, 64'h0, 32'h13579bdf);
    wait_reply_done("reuse_after_timeout");
  endtask

  task automatic test_gap_boundary();
    // Exactly GAP idle cycles between two key bytes: byte still wins.
    expect_ok(K2, 32'h55aa00ff, 1'b1);
    send_byte(8'h01);
    for (int i = 7; i >= 4; i--) send_byte(K2[i*8 +: 8]);
    repeat (GAP) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_edge_hold: busy=%b tx_valid=%b, required 1/0", busy, tx_valid);
    end
    for (int i = 3; i >= 0; i--) send_byte(K2[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h55aa00ff >> (i*8)));
    wait_reply_done("gap_edge_ok");
    // GAP+1 idle cycles: timeout reply appears right after the last one.
    reply_q.push_back(8'hE3);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (GAP) @(posedge clk);
    #1;
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_early: tx_valid=%b after %0d idle, required 0", tx_valid, GAP);
    end
    @(posedge clk); #1;
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hE3) begin
      miscompares++;
      $display("FAIL gap_expire: tx_valid=%b tx_data=%h, required 1/e3", tx_valid, tx_data);
    end
    wait_reply_done("gap_edge_timeout");
  endtask

  task automatic test_backpressure();
    int n;
    expect_ok(K2, 32'h0badf00d, 1'b0);
    send_frame(8'h00, K2, 32'h0badf00d);
    n = 0;
    while (tx_valid !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_reply_done("backpressure");
  endtask

  task automatic test_reset_wait_core();
    int l0;
    core_lat = 20;
    core_q.push_back('{key: K2, blk: 32'h11223344, dec: 1'b1});
    send_frame(8'h01, K2, 32'h11223344);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || core_decrypt !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_core_state: busy=%b dec=%b, required 1/1", busy, core_decrypt);
    end
    rst = 1'b0;
    core_chk = 0;
    #1;
    vectors++;
    if ({rx_ready, tx_valid, core_load, core_decrypt, busy, done_pulse, err_flag} !== 7'b0 ||
        tx_data !== 8'h00 || core_key !== '0 || core_blk !== '0) begin
      miscompares++;
      $display("FAIL async_reset: ctl=%b tx_data=%h key=%h blk=%h, required all zero",
               {rx_ready, tx_valid, core_load, core_decrypt, busy, done_pulse, err_flag},
               tx_data, core_key, core_blk);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    core_lat = 3;
    l0 = load_cnt;
    reply_q.push_back(8'hE2);
    send_frame(8'h02, 64'h0, 32'h11223344);
    wait_reply_done("reuse_after_reset");
    vectors++;
    if (load_cnt != l0 || err_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL key_cleared: loads=%0d err_flag=%b, required 0/1", load_cnt - l0, err_flag);
    end
  endtask

  initial begin
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    core_done = 1'b0;
    core_result = '0;
    test_reset();
    test_encrypt();
    test_decrypt_reuse();
    test_nokey();
    test_badmode();
    test_timeout();
    test_gap_boundary();
    test_backpressure();
    test_reset_wait_core();
    repeat (5) @(posedge clk);
    vectors++;
    if (core_q.size() != 0 || reply_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: core=%0d reply=%0d, required 0/0", core_q.size(), reply_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
